// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with one 8-byte word per line.
// Serves one IFU fetch at a time and refills misses from memory.
module icache_responder #(
  parameter int LINES = 16,
  parameter int TAG_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_rd_req,
  input  logic [63:0] icache_rd_addr,
  input  logic [3:0]  icache_rd_wstrb,
  input  logic        fence_i,
  output logic [63:0] icache_ret_data,
  output logic        icache_ret_valid,
  output logic        if_stall,
  output logic        mem_rd_req,
  output logic [63:0] mem_rd_addr,
  input  logic        mem_rd_valid,
  input  logic [63:0] mem_rd_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [63:3]        addr_q;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_arr  [LINES];
  logic [63:0]        data_arr [LINES];
  logic [63:0]        refill_word;
  logic [63:0]        last_word;
  logic               fence_seen;
  logic               hit;
  logic               refill_now;
  logic               unused_bits;

  assign unused_bits = ^{icache_rd_wstrb, icache_rd_addr[2:0]};

  assign idx         = addr_q[IDX_W+2:3];
  assign tag         = addr_q[TAG_W+IDX_W+2:IDX_W+3];
  assign hit         = valid_q[idx] && (tag_arr[idx] == tag);
  assign refill_now  = (state == MISS) && mem_rd_valid;
  assign mem_rd_addr = {addr_q, 3'b000};
  assign if_stall    = ((state != IDLE) || icache_rd_req) && !icache_ret_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    icache_ret_valid = 1'b0;
    mem_rd_req       = 1'b0;
    icache_ret_data  = last_word;
    unique case (state)
      IDLE: begin
        if (icache_rd_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          icache_ret_valid = 1'b1;
          icache_ret_data  = data_arr[idx];
          state_nxt        = IDLE;
        end else begin
          state_nxt = MISS;
        end
      end
      MISS: begin
        mem_rd_req = 1'b1;
        if (mem_rd_valid) state_nxt = REFILL;
      end
      REFILL: begin
        icache_ret_valid = 1'b1;
        icache_ret_data  = refill_word;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      refill_word <= '0;
      last_word   <= '0;
    end else begin
      if (state == IDLE && icache_rd_req) addr_q <= icache_rd_addr[63:3];
      if (refill_now) refill_word <= mem_rd_data;
      if (icache_ret_valid) last_word <= icache_ret_data;
    end
  end

  // A fence seen while the refill is outstanding makes the incoming word stale for the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fence_seen <= 1'b0;
    end else if (state == IDLE) begin
      fence_seen <= 1'b0;
    end else if (fence_i && state == MISS) begin
      fence_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fence_i) begin
      valid_q <= '0;
    end else if (refill_now && !fence_seen) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_now) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Scoreboard bench for icache_responder: fetches push the expected word,
// a negedge monitor pops and compares every returned word.
module tb_icache_responder;

  logic        clk;
  logic        rst;
  logic        icache_rd_req;
  logic [63:0] icache_rd_addr;
  logic [3:0]  icache_rd_wstrb;
  logic        fence_i;
  logic [63:0] icache_ret_data;
  logic        icache_ret_valid;
  logic        if_stall;
  logic        mem_rd_req;
  logic [63:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int          checks;
  int          errors;
  int          exp_hits;
  int          exp_misses;
  logic [63:0] exp_q [$];
  logic [63:0] exp_word;
  logic [63:0] last_ret;

  icache_responder #(.LINES(16), .TAG_W(25)) dut (
    .clk              (clk),
    .rst              (rst),
    .icache_rd_req    (icache_rd_req),
    .icache_rd_addr   (icache_rd_addr),
    .icache_rd_wstrb  (icache_rd_wstrb),
    .fence_i          (fence_i),
    .icache_ret_data  (icache_ret_data),
    .icache_ret_valid (icache_ret_valid),
    .if_stall         (if_stall),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_data      (mem_rd_data),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Backing memory contents; 0x8000_0000 holds the canonical boot word.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0000_0093;
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (icache_ret_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ret", 64'd1, 64'd0);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("ret_data", icache_ret_data, exp_word);
          last_ret = exp_word;
        end
        checkOutput("ret_stall", {63'd0, if_stall}, 64'd0);
      end else begin
        checkOutput("ret_hold", icache_ret_data, last_ret);
      end
    end
  end

  // One fetch, called at a negedge in IDLE; also plays the memory side.
  task automatic applyStimulus(input logic [63:0] addr, input bit exp_hit,
                               input int mem_lat, input int fence_at);
    int  first_req;
    int  valid_cyc;
    bit  done;
    bit  saw_req;
    logic [63:0] line_addr;
    line_addr = {addr[63:3], 3'b000};
    first_req = -1;
    valid_cyc = -1;
    done      = 1'b0;
    saw_req   = 1'b0;
    exp_q.push_back(mem_word(line_addr));
    icache_rd_req   = 1'b1;
    icache_rd_addr  = addr;
    icache_rd_wstrb = 4'($urandom);
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      icache_rd_addr = addr ^ 64'h180;
      fence_i        = (cyc == fence_at);
      mem_rd_valid   = 1'b0;
      if (icache_ret_valid) begin
        done = 1'b1;
        icache_rd_req = 1'b0;
        if (exp_hit) checkOutput("hit_latency", 64'(cyc), 64'd1);
        else         checkOutput("miss_latency", 64'(cyc), 64'(valid_cyc + 1));
      end else begin
        checkOutput("busy_stall", {63'd0, if_stall}, 64'd1);
        if (mem_rd_req) begin
          if (!saw_req) begin
            saw_req   = 1'b1;
            first_req = cyc;
            checkOutput("mem_req_latency", 64'(cyc), 64'd2);
          end
          checkOutput("mem_rd_addr", mem_rd_addr, line_addr);
          if (cyc - first_req == mem_lat) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(line_addr);
            valid_cyc    = cyc;
          end
        end
      end
    end
    if (!done) begin
      checkOutput("timeout", 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      icache_rd_req = 1'b0;
    end
    checkOutput("mem_req_seen", {63'd0, saw_req}, {63'd0, !exp_hit});
    mem_rd_valid = 1'b0;
    @(negedge clk);
    fence_i = 1'b0;
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    checkOutput("hit_cnt", {32'd0, hit_cnt}, 64'(exp_hits));
    checkOutput("miss_cnt", {32'd0, miss_cnt}, 64'(exp_misses));
    checkOutput("idle_stall", {63'd0, if_stall}, 64'd0);
  endtask

  task automatic pulse_fence();
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
  endtask

  initial begin
    int waited;
    checks = 0; errors = 0; exp_hits = 0; exp_misses = 0; last_ret = '0;
    rst = 1'b0; icache_rd_req = 1'b0; icache_rd_addr = '0; icache_rd_wstrb = '0;
    fence_i = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ret_valid", {63'd0, icache_ret_valid}, 64'd0);
    checkOutput("rst_ret_data", icache_ret_data, 64'd0);
    checkOutput("rst_mem_req", {63'd0, mem_rd_req}, 64'd0);
    checkOutput("rst_hit_cnt", {32'd0, hit_cnt}, 64'd0);
    checkOutput("rst_miss_cnt", {32'd0, miss_cnt}, 64'd0);
    checkOutput("rst_stall", {63'd0, if_stall}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold miss, hit, then index-0 conflict thrash.
    applyStimulus(64'h8000_0004, 1'b0, 3, -1);
    applyStimulus(64'h8000_0000, 1'b1, 0, -1);
    applyStimulus(64'h8000_0080, 1'b0, 1, -1);
    applyStimulus(64'h8000_0000, 1'b0, 2, -1);
    applyStimulus(64'h8000_0010, 1'b0, 0, -1);
    applyStimulus(64'h8000_0014, 1'b1, 0, -1);

    // Fence after fill; then fence during a hitting lookup still hits.
    pulse_fence();
    applyStimulus(64'h8000_0000, 1'b0, 1, -1);
    applyStimulus(64'h8000_0010, 1'b0, 1, -1);
    applyStimulus(64'h8000_0000, 1'b1, 0, 1);
    applyStimulus(64'h8000_0000, 1'b0, 2, -1);

    // Fence mid-miss, and fence coincident with the refill write.
    applyStimulus(64'h8000_0080, 1'b0, 4, 3);
    applyStimulus(64'h8000_0080, 1'b0, 1, -1);
    applyStimulus(64'h8000_0000, 1'b0, 1, 3);
    applyStimulus(64'h8000_0000, 1'b0, 1, -1);
    applyStimulus(64'h8000_0000, 1'b1, 0, -1);

    // Stray refill data while idle must be ignored.
    mem_rd_valid = 1'b1;
    mem_rd_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    checkOutput("stray_valid_stall", {63'd0, if_stall}, 64'd0);
    applyStimulus(64'h8000_0004, 1'b1, 0, -1);

    // Reset while a refill is outstanding.
    icache_rd_req  = 1'b1;
    icache_rd_addr = 64'h8000_0100;
    waited = 0;
    while (!mem_rd_req && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rst_mid_miss_req", {63'd0, mem_rd_req}, 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_mem_req", {63'd0, mem_rd_req}, 64'd0);
    checkOutput("rst_mid_ret_valid", {63'd0, icache_ret_valid}, 64'd0);
    checkOutput("rst_mid_hit_cnt", {32'd0, hit_cnt}, 64'd0);
    checkOutput("rst_mid_miss_cnt", {32'd0, miss_cnt}, 64'd0);
    checkOutput("rst_mid_ret_data", icache_ret_data, 64'd0);
    icache_rd_req = 1'b0;
    exp_hits = 0; exp_misses = 0; last_ret = '0;
    @(negedge clk);
    rst = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    checkOutput("late_valid_stall", {63'd0, if_stall}, 64'd0);
    @(negedge clk);
    applyStimulus(64'h8000_0000, 1'b0, 2, -1);
    applyStimulus(64'h8000_0000, 1'b1, 0, -1);

    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
